// File: rtl/lut_ram_2port.sv
// lut_ram_2port: simple dual-port LUT RAM with one write port and one
// independent read port on a single clock.
//   - Per-byte write enables (wr_be), one lane per BYTE_W bits.
//   - Read latency RD_LAT of 1 or 2 cycles, fully pipelined.
//   - RDW_MODE selects old (0) or merged new (1) data on a same-address
//     read during write.
//   - A clear engine zero-fills the array after reset (CLEAR_ON_RST) or
//     on clr_req. User ports are ignored while it runs.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   wr_en/addr/data/be  write request, address, data, byte-lane enables
//   rd_en/addr          read request and address
//   rd_data, rd_valid   read result and its one-cycle valid pulse
//   clr_req             start a clear sweep (honoured in IDLE only)
//   init_busy           clear sweep in progress
module lut_ram_2port #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned DEPTH        = 16384,
    parameter int unsigned BYTE_W       = 8,
    parameter int unsigned RD_LAT       = 1,
    parameter int unsigned RDW_MODE     = 0,
    parameter int unsigned CLEAR_ON_RST = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [$clog2(DEPTH)-1:0]  wr_addr,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic [WIDTH/BYTE_W-1:0]   wr_be,
    input  logic                      rd_en,
    input  logic [$clog2(DEPTH)-1:0]  rd_addr,
    output logic [WIDTH-1:0]          rd_data,
    output logic                      rd_valid,
    input  logic                      clr_req,
    output logic                      init_busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned NB = WIDTH / BYTE_W;
    // One extra bit so DEPTH itself is representable for range checks.
    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t           state;
    logic [AW-1:0]    clr_cnt;
    logic [WIDTH-1:0] mem [DEPTH];

    logic             wr_ok;
    logic             rd_ok;
    logic [WIDTH-1:0] old_word;
    logic [WIDTH-1:0] merged_word;
    logic [WIDTH-1:0] rd_word;

    always_comb begin
        wr_ok = (state == IDLE) && wr_en && ({1'b0, wr_addr} < DEPTH_W);
        rd_ok = (state == IDLE) && rd_en;

        old_word = '0;
        if ({1'b0, rd_addr} < DEPTH_W) begin
            old_word = mem[rd_addr];
        end

        // Word as it will look after this cycle's write, if the write
        // targets the same address.
        merged_word = old_word;
        for (int unsigned i = 0; i < NB; i++) begin
            if (wr_be[i]) begin
                merged_word[i*BYTE_W +: BYTE_W] = wr_data[i*BYTE_W +: BYTE_W];
            end
        end

        rd_word = old_word;
        if ((RDW_MODE == 1) && wr_ok && (wr_addr == rd_addr)) begin
            rd_word = merged_word;
        end
    end

    // Storage has no reset; the clear engine is the only way to zero it.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (wr_ok) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][i*BYTE_W +: BYTE_W] <= wr_data[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= (CLEAR_ON_RST != 0) ? CLEAR : IDLE;
            clr_cnt   <= '0;
            init_busy <= (CLEAR_ON_RST != 0);
        end else begin
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state     <= CLEAR;
                        clr_cnt   <= '0;
                        init_busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (clr_cnt == LAST) begin
                        state     <= IDLE;
                        clr_cnt   <= '0;
                        init_busy <= 1'b0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    clr_cnt   <= '0;
                    init_busy <= 1'b0;
                end
            endcase
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic             s1_valid;
            logic [WIDTH-1:0] s1_data;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s1_valid <= 1'b0;
                    s1_data  <= '0;
                    rd_valid <= 1'b0;
                    rd_data  <= '0;
                end else begin
                    s1_valid <= rd_ok;
                    if (rd_ok) begin
                        s1_data <= rd_word;
                    end
                    rd_valid <= s1_valid;
                    if (s1_valid) begin
                        rd_data <= s1_data;
                    end
                end
            end
        end else begin : g_lat1
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_valid <= 1'b0;
                    rd_data  <= '0;
                end else begin
                    rd_valid <= rd_ok;
                    if (rd_ok) begin
                        rd_data <= rd_word;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_lut_ram_2port.sv
// Scoreboard bench for lut_ram_2port. Three instances share stimulus:
//   u0: DEPTH 16, RD_LAT 1, old-data collisions
//   u1: DEPTH 16, RD_LAT 2, new-data collisions
//   u2: DEPTH 12, RD_LAT 1, new-data collisions (addresses 12..15 out of range)
module tb_lut_ram_2port;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_be = '0;
    logic        rd_en = 1'b0;
    logic [3:0]  rd_addr = '0;
    logic        clr_req = 1'b0;

    logic [31:0] rd_data [3];
    logic        rd_valid [3];
    logic        busy [3];

    always #5 clk = ~clk;

    lut_ram_2port #(.WIDTH(32), .DEPTH(16), .BYTE_W(8), .RD_LAT(1), .RDW_MODE(0), .CLEAR_ON_RST(1)) u0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data[0]), .rd_valid(rd_valid[0]),
        .clr_req(clr_req), .init_busy(busy[0]));

    lut_ram_2port #(.WIDTH(32), .DEPTH(16), .BYTE_W(8), .RD_LAT(2), .RDW_MODE(1), .CLEAR_ON_RST(1)) u1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data[1]), .rd_valid(rd_valid[1]),
        .clr_req(clr_req), .init_busy(busy[1]));

    lut_ram_2port #(.WIDTH(32), .DEPTH(12), .BYTE_W(8), .RD_LAT(1), .RDW_MODE(1), .CLEAR_ON_RST(1)) u2 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data[2]), .rd_valid(rd_valid[2]),
        .clr_req(clr_req), .init_busy(busy[2]));

    // Reference configuration of each instance.
    int unsigned dep [3] = '{16, 16, 12};
    int unsigned lat [3] = '{1, 2, 1};
    bit          rdw [3] = '{1'b0, 1'b1, 1'b1};

    // Reference memory contents.
    logic [31:0] m [3][16];

    typedef struct {
        int unsigned cyc;
        logic [31:0] data;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int unsigned cyc = 0;
    int          checks = 0;
    int          passes = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    function automatic int qsize(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic push(input int k, input exp_t e);
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic pop(input int k, output exp_t e);
        case (k)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        end
        return r;
    endfunction

    // Monitor: every rd_valid pulse must match the oldest pending expectation
    // both in data and in the cycle it was due; between pulses rd_data holds.
    logic [31:0] last [3];
    exp_t        mon_e;

    always @(negedge clk) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) last[k] = '0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (rd_valid[k]) begin
                    if (qsize(k) == 0) begin
                        chk($sformatf("u%0d_spurious_rd_valid", k), 32'(qsize(k)), 32'd1);
                    end else begin
                        pop(k, mon_e);
                        chk($sformatf("u%0d_rd_data", k), rd_data[k], mon_e.data);
                        chk($sformatf("u%0d_rd_latency_cycle", k), cyc, mon_e.cyc);
                    end
                    last[k] = rd_data[k];
                end else begin
                    chk($sformatf("u%0d_rd_data_hold", k), rd_data[k], last[k]);
                end
            end
        end
    end

    // Applies one cycle of stimulus; when apply is set the reference model
    // sees it too (apply is cleared for cycles the DUT must ignore).
    task automatic drive(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                         input logic [3:0] be, input logic re, input logic [3:0] ra,
                         input logic clr, input bit apply);
        exp_t e;
        wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
        rd_en = re; rd_addr = ra; clr_req = clr;
        if (apply) begin
            for (int k = 0; k < 3; k++) begin
                if (re) begin
                    e.cyc  = cyc + lat[k];
                    e.data = (32'(ra) < dep[k]) ? m[k][ra] : 32'h0;
                    if (rdw[k] && we && (wa == ra) && (32'(wa) < dep[k]))
                        e.data = merge(m[k][wa], wd, be);
                    push(k, e);
                end
                if (we && (32'(wa) < dep[k])) m[k][wa] = merge(m[k][wa], wd, be);
                if (clr) for (int a = 0; a < 16; a++) m[k][a] = '0;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0, 1'b0, 1'b1);
    endtask

    task automatic read_all();
        for (int a = 0; a < 16; a++) drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'(a), 1'b0, 1'b1);
        idle(3);
    endtask

    task automatic drive_random(input bit apply);
        logic [3:0] wa;
        logic [3:0] ra;
        wa = 4'($urandom_range(0, 15));
        ra = ($urandom_range(0, 2) == 0) ? wa : 4'($urandom_range(0, 15));
        drive(1'($urandom_range(0, 1)), wa, $urandom(), 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), ra, apply ? 1'b0 : 1'($urandom_range(0, 1)), apply);
    endtask

    // Asserts reset, checks reset outputs, releases it and counts the
    // automatic sweep length of each instance.
    task automatic reset_and_sweep();
        int bc [3];
        rst = 1'b1;
        wr_en = 1'b0; rd_en = 1'b0; clr_req = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("u%0d_rst_init_busy", k), 32'(busy[k]), 32'd1);
            chk($sformatf("u%0d_rst_rd_valid", k), 32'(rd_valid[k]), 32'd0);
            chk($sformatf("u%0d_rst_rd_data", k), rd_data[k], 32'h0);
        end
        q0.delete(); q1.delete(); q2.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bc[k] = 0;
            for (int a = 0; a < 16; a++) m[k][a] = '0;
        end
        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < 3; k++) if (busy[k]) bc[k]++;
            @(negedge clk);
        end
        for (int k = 0; k < 3; k++)
            chk($sformatf("u%0d_reset_sweep_len", k), 32'(bc[k]), dep[k]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc [3];

        @(negedge clk);
        @(negedge clk);
        reset_and_sweep();
        read_all();

        // Full-word writes then back-to-back reads.
        drive(1'b1, 4'd5,  32'hAAAABBBB, 4'hF, 1'b0, 4'd0, 1'b0, 1'b1);
        drive(1'b1, 4'd6,  32'h12345678, 4'hF, 1'b0, 4'd0, 1'b0, 1'b1);
        drive(1'b1, 4'd15, 32'hDEADBEEF, 4'hF, 1'b0, 4'd0, 1'b0, 1'b1);
        drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd5,  1'b0, 1'b1);
        drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd6,  1'b0, 1'b1);
        drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd15, 1'b0, 1'b1);
        idle(3);

        // Byte enables, including an all-zero enable.
        drive(1'b1, 4'd3, 32'h11223344, 4'hF,    1'b0, 4'd0, 1'b0, 1'b1);
        drive(1'b1, 4'd3, 32'hAABBCCDD, 4'b0101, 1'b0, 4'd0, 1'b0, 1'b1);
        drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd3, 1'b0, 1'b1);
        drive(1'b1, 4'd3, 32'hFFFFFFFF, 4'h0,    1'b0, 4'd0, 1'b0, 1'b1);
        drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd3, 1'b0, 1'b1);
        idle(3);

        // Same-address collision, then a plain read of the result.
        drive(1'b1, 4'd6, 32'hCAFEF00D, 4'hF, 1'b1, 4'd6, 1'b0, 1'b1);
        drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd6, 1'b0, 1'b1);
        idle(3);

        for (int i = 0; i < 400; i++) drive_random(1'b1);
        idle(3);
        read_all();

        // Runtime clear with a write and read in the request cycle; inputs
        // toggled during the sweep must have no effect.
        drive(1'b1, 4'd9, 32'h55556666, 4'hF, 1'b1, 4'd5, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) bc[k] = 0;
        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < 3; k++) if (busy[k]) bc[k]++;
            if (i < 10) drive_random(1'b0);
            else drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0, 1'b0, 1'b0);
        end
        for (int k = 0; k < 3; k++)
            chk($sformatf("u%0d_runtime_sweep_len", k), 32'(bc[k]), dep[k]);
        read_all();

        // Reset in the middle of a sweep restarts it from the beginning.
        drive(1'b1, 4'd2, 32'h0BADF00D, 4'hF, 1'b0, 4'd0, 1'b0, 1'b1);
        drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0, 1'b1, 1'b1);
        for (int i = 0; i < 7; i++) drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0, 1'b0, 1'b0);
        reset_and_sweep();
        read_all();

        for (int i = 0; i < 100; i++) drive_random(1'b1);
        idle(3);
        read_all();
        idle(2);

        for (int k = 0; k < 3; k++)
            chk($sformatf("u%0d_pending_reads", k), 32'(qsize(k)), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
